// File: rtl/arb_types_pkg.sv
// Shared types for the RAM port arbiter: FSM states, RAM handshake states, watchdog width.
// ramstate_t encoding is fixed by the RAM controller (FREE=0 .. ERROR=3).
package arb_types_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  localparam int TIMEOUT_W = 8;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Datapath/cache request bus plus RAM port bundle seen by the arbiter.
// slave = arbiter side, master = requesters and RAM model.
interface mem_port_arbiter_if
  import arb_types_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              halt;
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic [DATA_W-1:0] iload;
  logic              ihit;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic [DATA_W-1:0] dload;
  logic              dhit;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  ramstate_t         ramstate;
  logic              timeout;

  modport slave (
    input  halt, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, timeout
  );

  modport master (
    output halt, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, timeout
  );

endinterface

// File: rtl/arb_watchdog.sv
// Grant watchdog: loadable up-counter with clear, terminal compare at TIMEOUT_CYC-1 and a
// sticky expiry flag. expire_o is combinational so the FSM can leave the grant that same cycle.
module arb_watchdog
  import arb_types_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 load_i,
  input  logic [TIMEOUT_W-1:0] load_val_i,
  input  logic                 cnt_en_i,
  output logic                 expire_o,
  output logic                 flag_o
);

  // Count value k-1 during the k-th waiting cycle, so the TIMEOUT_CYC-th one is terminal.
  localparam logic [TIMEOUT_W-1:0] TERM = TIMEOUT_W'(TIMEOUT_CYC - 1);

  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 flag_q, flag_d;

  assign expire_o = cnt_en_i && (cnt_q == TERM);
  assign flag_o   = flag_q;

  always_comb begin
    cnt_d  = cnt_q;
    flag_d = flag_q | expire_o;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_en_i) begin
      cnt_d = cnt_q + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one RAM port between fetch and load/store, data first; registered grant, hit on ACCESS.
// Optional fetch-starvation guard under `ifdef ARB_FAIRNESS_EN (forces i after MAX_DSTREAK d-hits).
module mem_port_arbiter
  import arb_types_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
`ifdef ARB_FAIRNESS_EN
  parameter int MAX_DSTREAK = 4,
`endif
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  mem_port_arbiter_if.slave bus
);

  arb_state_t state_q, state_d;
  logic       dreq;
  logic       access;
  logic       req_held;
  logic       ihit, dhit;
  logic       force_i;
  logic       wd_expire;
  logic       wd_flag;

  assign dreq   = bus.dREN | bus.dWEN;
  assign access = (bus.ramstate == ACCESS);

  always_comb begin
    req_held = 1'b0;
    case (state_q)
      IGRANT:  req_held = bus.iREN;
      DGRANT:  req_held = dreq;
      default: req_held = 1'b0;
    endcase
  end

`ifdef ARB_FAIRNESS_EN
  localparam int STREAK_W = $clog2(MAX_DSTREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DSTREAK);

  logic [STREAK_W-1:0] streak_q, streak_d;

  // Only d-completions that overtook a waiting fetch count toward the streak.
  always_comb begin
    streak_d = streak_q;
    if (!bus.iREN || state_q == IGRANT) begin
      streak_d = '0;
    end else if (dhit && streak_q != STREAK_MAX) begin
      streak_d = streak_q + STREAK_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) streak_q <= '0;
    else       streak_q <= streak_d;
  end

  assign force_i = (streak_q == STREAK_MAX) && bus.iREN && !bus.halt;
`else
  assign force_i = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (force_i)                     state_d = IGRANT;
        else if (dreq)                   state_d = DGRANT;
        else if (bus.iREN && !bus.halt)  state_d = IGRANT;
      end
      // Dropped request beats ACCESS: the requester no longer wants the data.
      IGRANT, DGRANT: begin
        if (!req_held || access || wd_expire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = {ADDR_W{1'b0}};
    bus.ramstore = {DATA_W{1'b0}};
    ihit         = 1'b0;
    dhit         = 1'b0;
    case (state_q)
      IGRANT: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = bus.iaddr;
        ihit        = access && bus.iREN;
      end
      DGRANT: begin
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN && !bus.dWEN;
        dhit         = access && dreq;
      end
      default: ;
    endcase
  end

  assign bus.ihit    = ihit;
  assign bus.dhit    = dhit;
  assign bus.iload   = ihit ? bus.ramload : {DATA_W{1'b0}};
  assign bus.dload   = dhit ? bus.ramload : {DATA_W{1'b0}};
  assign bus.timeout = wd_flag;

  arb_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk        (CLK),
    .rst_n      (nRST),
    .clr_i      (state_d != state_q),
    .load_i     (1'b0),
    .load_val_i ({TIMEOUT_W{1'b0}}),
    .cnt_en_i   (req_held && !access),
    .expire_o   (wd_expire),
    .flag_o     (wd_flag)
  );

endmodule
